sdf_r2_stage: RTL

Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the pipelined FFT datapath. It generalises the fixed depth-1 radix-2 SDF unit to any power-of-two delay depth, accepts gapped input, and drains the final frame on request. Output arithmetic is either saturating or scale-by-half. One instance per FFT stage, chained with twiddle multipliers between stages.

---
 rtl/sdf_r2_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with a DEPTH-sample feedback line.
// Define SDF_R2_SCALE_EN to scale every output by 1/2 (optionally rounded); default saturates.
module sdf_r2_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int BF_RH = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   input  logic             flush,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im,
   output logic             busy
);

   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]           cnt;
   logic                    phase;
   logic                    primed;
   logic signed [WIDTH-1:0] dl_re [DEPTH];
   logic signed [WIDTH-1:0] dl_im [DEPTH];

   logic                    step;
   logic                    cnt_last;
   logic                    drain_end;
   logic signed [WIDTH-1:0] in_re, in_im;
   logic signed [WIDTH-1:0] x0_re, x0_im;
   logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
   logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;

   // Reduce a WIDTH+1-bit butterfly result back to WIDTH bits.
   function automatic logic signed [WIDTH-1:0] fit(input logic signed [WIDTH:0] v);
`ifdef SDF_R2_SCALE_EN
      logic signed [WIDTH+1:0] t;
      t = {v[WIDTH], v} + (WIDTH+2)'(BF_RH);
      return t[WIDTH:1];
`else
      if (v[WIDTH] != v[WIDTH-1])
         return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         return v[WIDTH-1:0];
`endif
   endfunction

`ifndef SDF_R2_SCALE_EN
   logic unused_rh;
   assign unused_rh = (BF_RH != 0);
`endif

   assign busy = primed | phase | (cnt != '0);

   // NOTE: every signal assigned in always_comb gets a value first, so no latch can be inferred.
   always_comb begin
      step      = di_en | (flush & busy);
      in_re     = di_en ? $signed(di_re) : '0;
      in_im     = di_en ? $signed(di_im) : '0;
      x0_re     = dl_re[DEPTH-1];
      x0_im     = dl_im[DEPTH-1];
      sum_re    = {x0_re[WIDTH-1], x0_re} + {in_re[WIDTH-1], in_re};
      sum_im    = {x0_im[WIDTH-1], x0_im} + {in_im[WIDTH-1], in_im};
      dif_re    = {x0_re[WIDTH-1], x0_re} - {in_re[WIDTH-1], in_re};
      dif_im    = {x0_im[WIDTH-1], x0_im} - {in_im[WIDTH-1], in_im};
      y0_re     = fit(sum_re);
      y0_im     = fit(sum_im);
      y1_re     = fit(dif_re);
      y1_im     = fit(dif_im);
      cnt_last  = (cnt == CW'(DEPTH - 1));
      // Injected sample that emits the final pending difference ends the drain.
      drain_end = !di_en && !phase && cnt_last && primed;
   end

   // NOTE: the delay line has no reset; its contents are never emitted until primed is set.
   always_ff @(posedge clock) begin
      if (step) begin
         dl_re[0] <= phase ? y1_re : in_re;
         dl_im[0] <= phase ? y1_im : in_im;
         for (int k = 1; k < DEPTH; k++) begin
            dl_re[k] <= dl_re[k-1];
            dl_im[k] <= dl_im[k-1];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         phase  <= 1'b0;
         primed <= 1'b0;
         do_en  <= 1'b0;
         do_re  <= '0;
         do_im  <= '0;
      end else begin
         do_en <= 1'b0;
         if (step) begin
            if (phase) begin
               do_en <= 1'b1;
               do_re <= y0_re;
               do_im <= y0_im;
            end else if (primed) begin
               do_en <= 1'b1;
               do_re <= x0_re;
               do_im <= x0_im;
            end

            if (drain_end) begin
               cnt    <= '0;
               phase  <= 1'b0;
               primed <= 1'b0;
            end else if (cnt_last) begin
               cnt   <= '0;
               phase <= ~phase;
               if (phase)
                  primed <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
